// File: rtl/sdram_arbiter_if.sv
// Bundle between the two requesters (A = CPU, B = DMA/debug), the arbiter and
// the sdram_block user port. "master" is the requester/controller side, "slave" the arbiter.
interface sdram_arbiter_if #(
  parameter int unsigned AW = 24,
  parameter int unsigned DW = 16
) ();

  // Requester A
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wr_data;
  logic          a_wr_en;
  logic          a_rd_en;
  logic          a_gnt;
  logic [DW-1:0] a_rd_data;
  logic          a_rd_ready;
  logic          a_rd_ack;

  // Requester B
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wr_data;
  logic          b_wr_en;
  logic          b_rd_en;
  logic          b_gnt;
  logic [DW-1:0] b_rd_data;
  logic          b_rd_ready;
  logic          b_rd_ack;

  // sdram_block user port
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wr_data;
  logic          ram_wr_en;
  logic          ram_rd_en;
  logic          ram_busy;
  logic [DW-1:0] ram_rd_data;
  logic          ram_rd_ready;
  logic          ram_rd_ack;

  modport master (
    output a_addr, a_wr_data, a_wr_en, a_rd_en, a_rd_ack,
    input  a_gnt, a_rd_data, a_rd_ready,
    output b_addr, b_wr_data, b_wr_en, b_rd_en, b_rd_ack,
    input  b_gnt, b_rd_data, b_rd_ready,
    input  ram_addr, ram_wr_data, ram_wr_en, ram_rd_en, ram_rd_ack,
    output ram_busy, ram_rd_data, ram_rd_ready
  );

  modport slave (
    input  a_addr, a_wr_data, a_wr_en, a_rd_en, a_rd_ack,
    output a_gnt, a_rd_data, a_rd_ready,
    input  b_addr, b_wr_data, b_wr_en, b_rd_en, b_rd_ack,
    output b_gnt, b_rd_data, b_rd_ready,
    output ram_addr, ram_wr_data, ram_wr_en, ram_rd_en, ram_rd_ack,
    input  ram_busy, ram_rd_data, ram_rd_ready
  );

endinterface

// File: rtl/sdram_arbiter.sv
// Two-master arbiter in front of sdram_block: one transaction at a time
// (IDLE -> ISSUE -> WAIT [-> RDATA]), round-robin or fixed-A priority, sticky timeout flag.
module sdram_arbiter #(
  parameter int unsigned AW         = 24,
  parameter int unsigned DW         = 16,
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic           clk,
  input  logic           rst,
  sdram_arbiter_if.slave bus,
  output logic           owner,
  output logic           err_timeout
);

  localparam int unsigned   CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RDATA
  } state_e;

  state_e        state_q;
  logic          last_b_q;
  logic          owner_q;
  logic          err_q;
  logic          lat_wr_q;
  logic [AW-1:0] lat_addr_q;
  logic [DW-1:0] lat_data_q;
  logic [CW-1:0] cnt_q;

  logic [AW-1:0] ram_addr_q;
  logic [DW-1:0] ram_wr_data_q;
  logic          ram_wr_en_q;
  logic          ram_rd_en_q;
  logic          ram_rd_ack_q;
  logic          a_gnt_q;
  logic          b_gnt_q;
  logic          a_rd_ready_q;
  logic          b_rd_ready_q;
  logic [DW-1:0] a_rd_data_q;
  logic [DW-1:0] b_rd_data_q;

  logic req_a;
  logic req_b;
  logic pick_b;
  logic owner_ack;

  assign req_a = bus.a_wr_en | bus.a_rd_en;
  assign req_b = bus.b_wr_en | bus.b_rd_en;

  // last_b_q only moves on real conflicts, so alternation is between contended grants
  assign pick_b    = (req_a && req_b) ? (FIXED_PRIO ? 1'b0 : ~last_b_q) : req_b;
  assign owner_ack = owner_q ? bus.b_rd_ack : bus.a_rd_ack;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      last_b_q      <= 1'b1;
      owner_q       <= 1'b0;
      err_q         <= 1'b0;
      lat_wr_q      <= 1'b0;
      lat_addr_q    <= '0;
      lat_data_q    <= '0;
      cnt_q         <= '0;
      ram_addr_q    <= '0;
      ram_wr_data_q <= '0;
      ram_wr_en_q   <= 1'b0;
      ram_rd_en_q   <= 1'b0;
      ram_rd_ack_q  <= 1'b0;
      a_gnt_q       <= 1'b0;
      b_gnt_q       <= 1'b0;
      a_rd_ready_q  <= 1'b0;
      b_rd_ready_q  <= 1'b0;
      a_rd_data_q   <= '0;
      b_rd_data_q   <= '0;
    end else begin
      ram_wr_en_q  <= 1'b0;
      ram_rd_en_q  <= 1'b0;
      ram_rd_ack_q <= 1'b0;
      a_gnt_q      <= 1'b0;
      b_gnt_q      <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (!bus.ram_busy && (req_a || req_b)) begin
            owner_q <= pick_b;
            if (req_a && req_b) begin
              last_b_q <= pick_b;
            end
            // write wins over a simultaneous read on the same port
            lat_wr_q   <= pick_b ? bus.b_wr_en : bus.a_wr_en;
            lat_addr_q <= pick_b ? bus.b_addr : bus.a_addr;
            lat_data_q <= pick_b ? bus.b_wr_data : bus.a_wr_data;
            state_q    <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          ram_addr_q    <= lat_addr_q;
          ram_wr_data_q <= lat_data_q;
          ram_wr_en_q   <= lat_wr_q;
          ram_rd_en_q   <= ~lat_wr_q;
          a_gnt_q       <= ~owner_q;
          b_gnt_q       <= owner_q;
          cnt_q         <= '0;
          state_q       <= S_WAIT;
        end

        S_WAIT: begin
          if (lat_wr_q && !bus.ram_busy) begin
            state_q <= S_IDLE;
          end else if (!lat_wr_q && bus.ram_rd_ready) begin
            if (owner_q) begin
              b_rd_ready_q <= 1'b1;
              b_rd_data_q  <= bus.ram_rd_data;
            end else begin
              a_rd_ready_q <= 1'b1;
              a_rd_data_q  <= bus.ram_rd_data;
            end
            state_q <= S_RDATA;
          end else if (cnt_q == CNT_LAST) begin
            // abort: flag it and release any half-finished read in the controller
            err_q        <= 1'b1;
            ram_rd_ack_q <= ~lat_wr_q;
            state_q      <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        S_RDATA: begin
          if (owner_ack) begin
            ram_rd_ack_q <= 1'b1;
            a_rd_ready_q <= 1'b0;
            b_rd_ready_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_wr_data = ram_wr_data_q;
  assign bus.ram_wr_en   = ram_wr_en_q;
  assign bus.ram_rd_en   = ram_rd_en_q;
  assign bus.ram_rd_ack  = ram_rd_ack_q;
  assign bus.a_gnt       = a_gnt_q;
  assign bus.b_gnt       = b_gnt_q;
  assign bus.a_rd_ready  = a_rd_ready_q;
  assign bus.b_rd_ready  = b_rd_ready_q;
  assign bus.a_rd_data   = a_rd_data_q;
  assign bus.b_rd_data   = b_rd_data_q;
  assign owner           = owner_q;
  assign err_timeout     = err_q;

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Two-master arbiter sharing the single sdram_block user port between the CPU (port A) and an auxiliary DMA/debug master (port B).
- Sits between the masters and sdram_block on the mclk domain.
- Sequences one transaction at a time: issue, wait-busy, read-return handshake, with timeout detection.
- Round-robin arbitration by default; fixed priority to A is selectable.

Parameters:
- AW, 24, address width.
- DW, 16, data width.
- FIXED_PRIO, 0, 1 = port A always wins a conflict; 0 = round-robin.
- TIMEOUT, 1023, max cycles waiting for ram_rd_ready or ram_busy release before abort; counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  master clock (mclk)
- rst  in  1  asynchronous reset, active-low
- a_addr  in  AW  port A address
- a_wr_data  in  DW  port A write data
- a_wr_en  in  1  port A write request, level, held until a_gnt
- a_rd_en  in  1  port A read request, level, held until a_gnt
- a_gnt  out  1  one-cycle pulse: A's command issued
- a_rd_data  out  DW  read data to A
- a_rd_ready  out  1  read data valid for A, held until a_rd_ack
- a_rd_ack  in  1  A consumed read data
- b_*  same set as a_* for port B
- ram_addr  out  AW  to sdram_block
- ram_wr_data  out  DW  to sdram_block
- ram_wr_en  out  1  one-cycle command pulse
- ram_rd_en  out  1  one-cycle command pulse
- ram_busy  in  1  controller busy
- ram_rd_data  in  DW  controller read data
- ram_rd_ready  in  1  controller read data valid
- ram_rd_ack  out  1  one-cycle pulse releasing ram_rd_ready
- owner  out  1  0 = A, 1 = B; current or last grant
- err_timeout  out  1  sticky; cleared only by reset

Behaviour:
- Reset (rst low, asynchronous, any state): state = IDLE; all outputs 0, including owner; last-winner register = B, so A wins the first conflict.
- States: IDLE, ISSUE, WAIT, RDATA.
- IDLE, entered when ram_busy = 0 and any request is pending:
  - Pick a winner. With one requester, that requester wins. On a conflict, FIXED_PRIO=1 picks A; otherwise the port that did not win last time.
  - Latch the winner's addr, data and op; update owner; go to ISSUE.
- ISSUE (exactly 1 cycle):
  - Pulse ram_wr_en or ram_rd_en with the latched addr/data; pulse the winner's gnt in the same cycle.
  - Clear the timeout counter; go to WAIT.
- Same-port op conflict: a_wr_en and a_rd_en both high is treated as a write; the read stays pending and must be re-arbitrated.
- Command outputs hold the latched values until the next ISSUE; they are not combinational from the requesters.
- WAIT (minimum 1 cycle, so the controller has time to raise ram_busy):
  - Write: return to IDLE when ram_busy = 0.
  - Read: go to RDATA when ram_rd_ready = 1.
  - The counter increments every WAIT cycle. On reaching TIMEOUT: set err_timeout, pulse ram_rd_ack if the op was a read, go to IDLE. The requester receives no rd_ready.
- RDATA:
  - owner's rd_ready = 1 and rd_data = ram_rd_data, registered one cycle after ram_rd_ready.
  - The non-owner's rd_ready stays 0 and its rd_data holds its last value.
  - On the owner's rd_ack: pulse ram_rd_ack, drop rd_ready the next cycle, go to IDLE.
  - rd_ack while rd_ready = 0 is ignored.
- Latency, uncontended read with a 0-wait controller: request to gnt = 2 cycles (IDLE, ISSUE). Minimum back-to-back command spacing = 3 cycles.
- A requester dropping its request before gnt withdraws it, unless already latched in ISSUE; a latched request is completed regardless.
- A ram_rd_ready that is not expected (seen in IDLE or during a write) is ignored and not acked.

Test Plan:
- A read 0x000010 alone; controller returns 0xBEEF 5 cycles later → a_gnt at cycle 2, ram_rd_en pulse with ram_addr = 0x000010, a_rd_ready with a_rd_data = 0xBEEF until a_rd_ack, one ram_rd_ack pulse, b_* idle.
- A write 0x123456/0xA5A5 and B write 0x000001/0x5A5A raised the same cycle, FIXED_PRIO=0 → A issued first, B issued ≥3 cycles later. Repeating the conflict → B wins first. With FIXED_PRIO=1 → A wins both times.
- A holds a_rd_en continuously while B requests a write, FIXED_PRIO=0 → grants alternate A, B, A; B is never starved beyond one A transaction.
- TIMEOUT=15, controller never asserts ram_rd_ready after a B read → err_timeout rises after 15 WAIT cycles, ram_rd_ack pulses, state returns to IDLE, a subsequent A write completes normally, err_timeout stays 1.
- rst driven low during RDATA with a_rd_ready=1 → a_rd_ready, ram_rd_ack, gnt and command outputs all 0 immediately (asynchronously). After release with no requests → no ram_*_en activity.
- a_wr_en and a_rd_en both high on 0x000020 → a write is issued, then the read is issued on re-arbitration.
